// File: rtl/tinysoc_pkg.sv
// Constants and state encoding shared between the ROM streamer and the
// tinysoc target's program-ROM loader.
package tinysoc_pkg;

  localparam int WORD_W    = 15;
  localparam int QUINT_W   = 5;
  localparam int NUM_WORDS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_STREAM
  } state_t;

endpackage : tinysoc_pkg

// File: rtl/rom_quintet_streamer_quintet_sel.sv
// Selects one quintet of an instruction word: phase 0 is the low quintet,
// phase 2 the high one. Mirrors the order the target reassembles words in.
module quintet_sel #(
  parameter int WORD_W  = tinysoc_pkg::WORD_W,
  parameter int QUINT_W = tinysoc_pkg::QUINT_W
) (
  input  logic [WORD_W-1:0]  i_word,
  input  logic [1:0]         i_phase,
  output logic [QUINT_W-1:0] o_quint
);

  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    o_quint = '0;
    unique case (i_phase)
      2'd0:    o_quint = i_word[QUINT_W-1:0];
      2'd1:    o_quint = i_word[2*QUINT_W-1:QUINT_W];
      2'd2:    o_quint = i_word[3*QUINT_W-1:2*QUINT_W];
      default: o_quint = '0;
    endcase
  end

endmodule : quintet_sel

// File: rtl/rom_quintet_streamer.sv
// Host-side tinysoc program-ROM loader: buffers instruction words, pulses
// the target reset, then streams 3*NUM_WORDS quintets onto io_in[7:3].
module rom_quintet_streamer #(
  parameter int NUM_WORDS  = tinysoc_pkg::NUM_WORDS,
  parameter int WORD_W     = tinysoc_pkg::WORD_W,
  parameter int QUINT_W    = tinysoc_pkg::QUINT_W,
  parameter int RST_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  input  logic [WORD_W-1:0]              s_data,
  output logic                           s_ready,
  input  logic                           start,
  input  logic                           clear,
  output logic                           busy,
  output logic                           done,
  output logic                           tgt_rst,
  output logic [QUINT_W-1:0]             tgt_q,
  output logic [$clog2(NUM_WORDS):0]     word_cnt
);

  import tinysoc_pkg::*;

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [WORD_W-1:0]  r_buf [NUM_WORDS];
  state_t             r_state;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [IDX_W-1:0]   r_w;
  logic [1:0]         r_p;
  logic [RC_W-1:0]    r_rst_cnt;
  logic               r_running;
  logic               r_s_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_tgt_rst;
  logic [QUINT_W-1:0] r_tgt_q;

  logic               w_idle;
  logic               w_wr;
  logic               w_last;
  logic               w_in_image;
  logic [IDX_W-1:0]   w_nxt_w;
  logic [1:0]         w_nxt_p;
  logic [QUINT_W-1:0] w_q;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_wr       = w_idle & s_valid & r_s_ready & ~clear;
  assign w_last     = (r_w == IDX_W'(NUM_WORDS - 1)) && (r_p == 2'd2);
  assign w_in_image = ({1'b0, w_nxt_w} < r_word_cnt);

  // Position of the quintet to present next cycle; RESET primes (0,0).
  always_comb begin
    w_nxt_w = '0;
    w_nxt_p = '0;
    if (r_state == ST_STREAM) begin
      if (r_p == 2'd2) begin
        w_nxt_w = r_w + 1'b1;
        w_nxt_p = 2'd0;
      end else begin
        w_nxt_w = r_w;
        w_nxt_p = r_p + 2'd1;
      end
    end
  end

  quintet_sel #(
    .WORD_W  (WORD_W),
    .QUINT_W (QUINT_W)
  ) u_quintet_sel (
    .i_word  (r_buf[w_nxt_w]),
    .i_phase (w_nxt_p),
    .o_quint (w_q)
  );

  // NOTE: the buffer is deliberately not reset; word_cnt alone marks valid entries.
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_word_cnt[IDX_W-1:0]] <= s_data;
  end

  // NOTE: all state and output registers use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= '0;
      r_w        <= '0;
      r_p        <= '0;
      r_rst_cnt  <= '0;
      r_running  <= 1'b0;
      r_s_ready  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tgt_rst  <= 1'b1;
      r_tgt_q    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_tgt_rst <= ~r_running;
          r_tgt_q   <= '0;
          if (clear) begin
            r_word_cnt <= '0;
            r_s_ready  <= 1'b1;
          end else if (w_wr) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            r_s_ready  <= (r_word_cnt + 1'b1) < CNT_W'(NUM_WORDS);
          end
          if (start) begin
            r_state   <= ST_RESET;
            r_busy    <= 1'b1;
            r_s_ready <= 1'b0;
            r_tgt_rst <= 1'b1;
            r_rst_cnt <= RC_W'(RST_CYCLES - 1);
          end
        end
        ST_RESET: begin
          if (r_rst_cnt == '0) begin
            // Release the target together with quintet 0 so its first edge samples it.
            r_state   <= ST_STREAM;
            r_tgt_rst <= 1'b0;
            r_w       <= w_nxt_w;
            r_p       <= w_nxt_p;
            r_tgt_q   <= w_in_image ? w_q : '0;
          end else begin
            r_rst_cnt <= r_rst_cnt - 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_last) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_running <= 1'b1;
            r_tgt_rst <= 1'b0;
            r_tgt_q   <= '0;
            r_s_ready <= r_word_cnt < CNT_W'(NUM_WORDS);
            r_w       <= '0;
            r_p       <= '0;
          end else begin
            r_w     <= w_nxt_w;
            r_p     <= w_nxt_p;
            r_tgt_q <= w_in_image ? w_q : '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready  = r_s_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tgt_rst  = r_tgt_rst;
  assign tgt_q    = r_tgt_q;
  assign word_cnt = r_word_cnt;

endmodule : rom_quintet_streamer

// File: tb/tb_rom_quintet_streamer.sv
// Directed bench for rom_quintet_streamer: a word model builds the expected
// quintet stream into a scoreboard queue that is drained as the DUT streams.
module tb_rom_quintet_streamer;

  localparam int NUM_WORDS  = 8;
  localparam int WORD_W     = 15;
  localparam int QUINT_W    = 5;
  localparam int RST_CYCLES = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic [WORD_W-1:0]  s_data;
  logic               s_ready;
  logic               start;
  logic               clear;
  logic               busy;
  logic               done;
  logic               tgt_rst;
  logic [QUINT_W-1:0] tgt_q;
  logic [3:0]         word_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [WORD_W-1:0]  m_buf [NUM_WORDS];
  int                 m_cnt = 0;
  logic [QUINT_W-1:0] sb [$];
  logic [QUINT_W-1:0] obs_seq [3*NUM_WORDS];

  rom_quintet_streamer #(
    .NUM_WORDS  (NUM_WORDS),
    .WORD_W     (WORD_W),
    .QUINT_W    (QUINT_W),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .start    (start),
    .clear    (clear),
    .busy     (busy),
    .done     (done),
    .tgt_rst  (tgt_rst),
    .tgt_q    (tgt_q),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [WORD_W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    check({tag, ":s_ready"}, s_ready, (m_cnt < NUM_WORDS));
    if (m_cnt < NUM_WORDS) begin
      m_buf[m_cnt] = d;
      m_cnt++;
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_clear(input logic with_valid);
    clear   = 1'b1;
    s_valid = with_valid;
    s_data  = 15'h1111;
    m_cnt   = 0;
    tick();
    clear   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic enqueue_image();
    for (int w = 0; w < NUM_WORDS; w++)
      for (int p = 0; p < 3; p++)
        sb.push_back((w < m_cnt) ? QUINT_W'((m_buf[w] >> (5 * p)) & 15'h1F) : '0);
  endtask

  // Full load; optionally re-pulses start at stream cycle restart_at.
  task automatic do_load(input string tag, input int restart_at);
    int rst_hi;
    int n;
    logic [QUINT_W-1:0] e;
    enqueue_image();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ":busy_in_reset"}, busy, 1'b1);
    check({tag, ":s_ready_in_reset"}, s_ready, 1'b0);
    rst_hi = 0;
    while (tgt_rst && rst_hi < 10) begin
      rst_hi++;
      tick();
    end
    check({tag, ":tgt_rst_len"}, rst_hi, RST_CYCLES);
    n = 0;
    while (!done && n < 40) begin
      if (n == restart_at) start = 1'b1;
      e = (sb.size() > 0) ? sb.pop_front() : 'x;
      check({tag, ":tgt_q"}, tgt_q, e);
      if (n < 3 * NUM_WORDS) obs_seq[n] = tgt_q;
      if (n == 0) check({tag, ":tgt_rst_stream"}, tgt_rst, 1'b0);
      n++;
      tick();
      start = 1'b0;
    end
    check({tag, ":stream_len"}, n, 3 * NUM_WORDS);
    check({tag, ":sb_empty"}, sb.size(), 0);
    check({tag, ":done"}, done, 1'b1);
    check({tag, ":busy_after"}, busy, 1'b0);
    check({tag, ":tgt_q_after"}, tgt_q, '0);
    check({tag, ":tgt_rst_after"}, tgt_rst, 1'b0);
    tick();
    check({tag, ":done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int done_seen;
    logic [WORD_W-1:0] img [NUM_WORDS];
    img = '{15'h7ABC, 15'h0001, 15'h4210, 15'h1F1F, 15'h0000, 15'h3333, 15'h5555, 15'h2AAA};
    rst = 1'b1; s_valid = 1'b0; s_data = '0; start = 1'b0; clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset:s_ready", s_ready, 1'b1);
    check("reset:busy", busy, 1'b0);
    check("reset:done", done, 1'b0);
    check("reset:tgt_rst", tgt_rst, 1'b1);
    check("reset:tgt_q", tgt_q, '0);
    check("reset:word_cnt", word_cnt, 4'd0);

    // Full 8-word image.
    for (int i = 0; i < NUM_WORDS; i++) push("full", img[i]);
    check("full:word_cnt", word_cnt, 4'd8);
    check("full:s_ready", s_ready, 1'b0);
    do_load("full", -1);
    check("full:q0", obs_seq[0], 5'h1C);
    check("full:q1", obs_seq[1], 5'h15);
    check("full:q2", obs_seq[2], 5'h1E);
    check("full:q3", obs_seq[3], 5'h01);
    check("full:q4", obs_seq[4], 5'h00);
    check("full:word_cnt_kept", word_cnt, 4'd8);

    // Reload with a stray start mid-stream; target stays released in IDLE.
    tick();
    check("reload:idle_tgt_rst", tgt_rst, 1'b0);
    do_load("reload", 5);
    check("reload:q0", obs_seq[0], 5'h1C);
    check("reload:q23", obs_seq[23], 5'h0A);

    // Backpressure: 9th word dropped.
    do_clear(1'b0);
    check("bp:cleared", word_cnt, 4'd0);
    for (int i = 0; i < 9; i++) push("bp", 15'(16'h0100 + i));
    check("bp:word_cnt", word_cnt, 4'd8);
    check("bp:s_ready", s_ready, 1'b0);

    // Clear wins over a same-cycle write.
    do_clear(1'b0);
    push("pri", 15'h0ABC);
    push("pri", 15'h0DEF);
    check("pri:word_cnt_2", word_cnt, 4'd2);
    do_clear(1'b1);
    check("pri:word_cnt_0", word_cnt, 4'd0);
    check("pri:s_ready", s_ready, 1'b1);

    // Empty image streams zeros.
    do_load("empty", -1);

    // Partial image: 3 words then zeros.
    push("part", 15'h0FFF);
    push("part", 15'h1234);
    push("part", 15'h7FFF);
    do_load("part", -1);
    check("part:q2", obs_seq[2], 5'h03);
    check("part:q3", obs_seq[3], 5'h14);
    check("part:q8", obs_seq[8], 5'h1F);
    check("part:q9", obs_seq[9], 5'h00);
    check("part:q23", obs_seq[23], 5'h00);
    check("part:word_cnt", word_cnt, 4'd3);

    // Reset at stream cycle 10.
    enqueue_image();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10 && tgt_rst; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check("abort:tgt_q", tgt_q, sb.pop_front());
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    m_cnt = 0;
    check("abort:tgt_rst", tgt_rst, 1'b1);
    check("abort:tgt_q0", tgt_q, '0);
    check("abort:busy", busy, 1'b0);
    check("abort:word_cnt", word_cnt, 4'd0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort:no_done", done_seen, 0);
    check("abort:tgt_rst_held", tgt_rst, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_rom_quintet_streamer
